// File: rtl/history_pkg.sv
// ----------------------------------------------------------------------------
// history_pkg - polarity mode encoding and run-length width helper. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package history_pkg;

   typedef enum logic [1:0] {
      MODE_ONES  = 2'b00,
      MODE_ZEROS = 2'b01,
      MODE_BOTH  = 2'b10
   } mode_t;

   function automatic int calc_lw(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/history_chan.sv
// ----------------------------------------------------------------------------
// history_chan - one channel: saturating run counter, Mealy flags, hit edge. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module history_chan
   import history_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int LW    = calc_lw(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          valid,
   input  logic          clr,
   input  logic          a,
   input  logic [1:0]    mode,
   input  logic [LW-1:0] thresh,
   output logic [LW-1:0] run_len,
   output logic          x,
   output logic          y,
   output logic          hit,
   output logic          hit_rise
);

   localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);

   logic          last_q, last_d;
   logic [LW-1:0] cnt_q,  cnt_d;
   logic          hit_q,  hit_d;
   logic          rise_q, rise_d;
   logic [LW-1:0] w_cur;
   logic          w_pol_ok;
   logic          w_take;

   always_comb begin
      w_take = valid && !clr;

      // cnt_q == 0 means no history, so the first sample always starts a run of 1
      if ((cnt_q != '0) && (a == last_q))
         w_cur = (cnt_q >= C_DEPTH) ? C_DEPTH : cnt_q + 1'b1;
      else
         w_cur = LW'(1);

      case (mode_t'(mode))
         MODE_ONES:  w_pol_ok = a;
         MODE_ZEROS: w_pol_ok = !a;
         default:    w_pol_ok = 1'b1;
      endcase

      run_len = w_take ? w_cur : '0;
      x       = w_take && (w_cur >= LW'(2));
      y       = w_take && (w_cur >= LW'(3));
      hit     = w_take && (w_cur >= thresh) && w_pol_ok;

      last_d = last_q;
      cnt_d  = cnt_q;
      hit_d  = hit_q;
      rise_d = 1'b0;
      if (clr) begin
         last_d = 1'b0;
         cnt_d  = '0;
         hit_d  = 1'b0;
      end else if (valid) begin
         last_d = a;
         cnt_d  = w_cur;
         hit_d  = hit;
         rise_d = hit && !hit_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= 1'b0;
         cnt_q  <= '0;
         hit_q  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         last_q <= last_d;
         cnt_q  <= cnt_d;
         hit_q  <= hit_d;
         rise_q <= rise_d;
      end
   end

   assign hit_rise = rise_q;

endmodule

`default_nettype wire

// File: rtl/history_detector.sv
// ----------------------------------------------------------------------------
// history_detector - CH independent run-length history channels with shared controls. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module history_detector
   import history_pkg::*;
#(
   parameter int CH    = 4,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         valid,
   input  logic                         clr,
   input  logic [CH-1:0]                a,
   input  logic [1:0]                   mode,
   input  logic [calc_lw(DEPTH)-1:0]    thresh,
   output logic [CH*calc_lw(DEPTH)-1:0] run_len,
   output logic [CH-1:0]                x,
   output logic [CH-1:0]                y,
   output logic [CH-1:0]                hit,
   output logic [CH-1:0]                hit_rise
);

   localparam int LW = calc_lw(DEPTH);

   generate
      for (genvar i = 0; i < CH; i++) begin : g_chan
         history_chan #(
            .DEPTH (DEPTH),
            .LW    (LW)
         ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .valid    (valid),
            .clr      (clr),
            .a        (a[i]),
            .mode     (mode),
            .thresh   (thresh),
            .run_len  (run_len[i*LW +: LW]),
            .x        (x[i]),
            .y        (y[i]),
            .hit      (hit[i]),
            .hit_rise (hit_rise[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_history_detector.sv
// ----------------------------------------------------------------------------
// tb_history_detector - directed and randomized checks against a sample-history model. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_history_detector;

   localparam int CH    = 4;
   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH + 1);

   logic                clk = 1'b0;
   logic                reset;
   logic                valid;
   logic                clr;
   logic [CH-1:0]       a;
   logic [1:0]          mode;
   logic [LW-1:0]       thresh;
   logic [CH*LW-1:0]    run_len;
   logic [CH-1:0]       x;
   logic [CH-1:0]       y;
   logic [CH-1:0]       hit;
   logic [CH-1:0]       hit_rise;

   int n_tests = 0;
   int n_fail  = 0;

   history_detector #(
      .CH    (CH),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .valid    (valid),
      .clr      (clr),
      .a        (a),
      .mode     (mode),
      .thresh   (thresh),
      .run_len  (run_len),
      .x        (x),
      .y        (y),
      .hit      (hit),
      .hit_rise (hit_rise)
   );

   always #5 clk = ~clk;

   // Reference: the list of accepted samples since the last clear, plus the hit of the last one
   bit hist[CH][$];
   bit prev_hit[CH];
   bit exp_rise[CH];

   function automatic int m_run(int ch, bit s);
      int r = 1;
      for (int k = hist[ch].size() - 1; k >= 0; k--) begin
         if (hist[ch][k] != s) break;
         r++;
      end
      return (r > DEPTH) ? DEPTH : r;
   endfunction

   function automatic bit m_hit(int ch, bit s);
      bit pol;
      case (mode)
         2'b00:   pol = s;
         2'b01:   pol = !s;
         default: pol = 1'b1;
      endcase
      return (m_run(ch, s) >= int'(thresh)) && pol;
   endfunction

   function automatic void m_reset();
      for (int c = 0; c < CH; c++) begin
         hist[c].delete();
         prev_hit[c] = 1'b0;
         exp_rise[c] = 1'b0;
      end
   endfunction

   task automatic drive(input bit v, input bit c, input logic [CH-1:0] av);
      valid = v;
      clr   = c;
      a     = av;
      #3;
   endtask

   task automatic advance();
      bit h[CH];
      for (int c = 0; c < CH; c++) h[c] = m_hit(c, a[c]);
      @(posedge clk);
      for (int c = 0; c < CH; c++) begin
         if (clr) begin
            hist[c].delete();
            prev_hit[c] = 1'b0;
            exp_rise[c] = 1'b0;
         end else if (valid) begin
            exp_rise[c] = h[c] && !prev_hit[c];
            prev_hit[c] = h[c];
            hist[c].push_back(a[c]);
            if (hist[c].size() > DEPTH) void'(hist[c].pop_front());
         end else begin
            exp_rise[c] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic do_clear();
      drive(1'b0, 1'b1, '0);
      advance();
   endtask

   task automatic test_reset();
      reset = 1'b0; valid = 1'b0; clr = 1'b0; a = '0; mode = 2'b10; thresh = LW'(3);
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (hit_rise !== '0) begin n_fail++; $display("FAIL reset hit_rise: got %b want 0", hit_rise); end
      n_tests++; if (run_len !== '0) begin n_fail++; $display("FAIL reset run_len: got %h want 0", run_len); end
      n_tests++; if ((x | y | hit) !== '0) begin n_fail++; $display("FAIL reset flags: x=%b y=%b hit=%b want 0", x, y, hit); end
      reset = 1'b1;
   endtask

   task automatic test_legacy_run();
      int exp_rl[4] = '{1, 2, 3, 4};
      logic [CH-1:0] av;
      mode = 2'b10; thresh = LW'(3);
      for (int i = 0; i < 4; i++) begin
         av = CH'($urandom);
         av[0] = 1'b0;
         drive(1'b1, 1'b0, av);
         n_tests++; if (run_len[0 +: LW] !== LW'(exp_rl[i])) begin n_fail++; $display("FAIL legacy run_len s%0d: got %0d want %0d", i, run_len[0 +: LW], exp_rl[i]); end
         n_tests++; if (x[0] !== (i >= 1)) begin n_fail++; $display("FAIL legacy x s%0d: got %b want %b", i, x[0], (i >= 1)); end
         n_tests++; if (y[0] !== (i >= 2)) begin n_fail++; $display("FAIL legacy y s%0d: got %b want %b", i, y[0], (i >= 2)); end
         for (int c = 1; c < CH; c++) begin
            n_tests++; if (run_len[c*LW +: LW] !== LW'(m_run(c, av[c]))) begin n_fail++; $display("FAIL legacy other ch%0d run_len: got %0d want %0d", c, run_len[c*LW +: LW], m_run(c, av[c])); end
         end
         advance();
      end
   endtask

   task automatic test_saturation();
      logic [CH-1:0] av;
      mode = 2'b00; thresh = LW'(3);
      do_clear();
      for (int i = 0; i < 10; i++) begin
         av = CH'($urandom);
         av[1] = 1'b1;
         drive(1'b1, 1'b0, av);
         n_tests++; if (run_len[LW +: LW] !== LW'((i + 1 > DEPTH) ? DEPTH : i + 1)) begin n_fail++; $display("FAIL sat run_len s%0d: got %0d want %0d", i, run_len[LW +: LW], (i + 1 > DEPTH) ? DEPTH : i + 1); end
         n_tests++; if (hit[1] !== (i >= 2)) begin n_fail++; $display("FAIL sat hit s%0d: got %b want %b", i, hit[1], (i >= 2)); end
         advance();
         n_tests++; if (hit_rise[1] !== (i == 2)) begin n_fail++; $display("FAIL sat hit_rise s%0d: got %b want %b", i, hit_rise[1], (i == 2)); end
      end
   endtask

   task automatic test_mode_zeros();
      bit sa[5]    = '{1, 1, 1, 0, 0};
      bit ehit[5]  = '{0, 0, 0, 0, 1};
      bit ex[5]    = '{0, 1, 1, 0, 1};
      logic [CH-1:0] av;
      mode = 2'b01; thresh = LW'(2);
      do_clear();
      for (int i = 0; i < 5; i++) begin
         av = CH'($urandom);
         av[2] = sa[i];
         drive(1'b1, 1'b0, av);
         n_tests++; if (hit[2] !== ehit[i]) begin n_fail++; $display("FAIL zeros hit s%0d: got %b want %b", i, hit[2], ehit[i]); end
         n_tests++; if (x[2] !== ex[i]) begin n_fail++; $display("FAIL zeros x s%0d: got %b want %b", i, x[2], ex[i]); end
         advance();
      end
   endtask

   task automatic test_gap();
      logic [CH-1:0] av;
      mode = 2'b10; thresh = LW'(3);
      do_clear();
      for (int i = 0; i < 2; i++) begin
         av = CH'($urandom);
         av[3] = 1'b1;
         drive(1'b1, 1'b0, av);
         n_tests++; if (run_len[3*LW +: LW] !== LW'(i + 1)) begin n_fail++; $display("FAIL gap pre run_len s%0d: got %0d want %0d", i, run_len[3*LW +: LW], i + 1); end
         advance();
      end
      for (int g = 0; g < 5; g++) begin
         drive(1'b0, 1'b0, CH'($urandom));
         n_tests++; if ((run_len !== '0) || ((x | y | hit) !== '0)) begin n_fail++; $display("FAIL gap outputs g%0d: run_len=%h x=%b y=%b hit=%b want 0", g, run_len, x, y, hit); end
         advance();
         n_tests++; if (hit_rise !== '0) begin n_fail++; $display("FAIL gap hit_rise g%0d: got %b want 0", g, hit_rise); end
      end
      av = CH'($urandom);
      av[3] = 1'b1;
      drive(1'b1, 1'b0, av);
      n_tests++; if (run_len[3*LW +: LW] !== LW'(3)) begin n_fail++; $display("FAIL gap resume run_len: got %0d want 3", run_len[3*LW +: LW]); end
      n_tests++; if (hit[3] !== 1'b1) begin n_fail++; $display("FAIL gap resume hit: got %b want 1", hit[3]); end
      advance();
      n_tests++; if (hit_rise[3] !== 1'b1) begin n_fail++; $display("FAIL gap resume hit_rise: got %b want 1", hit_rise[3]); end
   endtask

   task automatic test_clear();
      logic [CH-1:0] av;
      mode = 2'b10; thresh = LW'(3);
      do_clear();
      for (int i = 0; i < 5; i++) begin
         av = CH'($urandom);
         av[0] = 1'b1;
         drive(1'b1, 1'b0, av);
         advance();
      end
      av = CH'($urandom);
      av[0] = 1'b1;
      drive(1'b1, 1'b1, av);
      n_tests++; if ((run_len !== '0) || ((x | y | hit) !== '0)) begin n_fail++; $display("FAIL clr outputs: run_len=%h x=%b y=%b hit=%b want 0", run_len, x, y, hit); end
      advance();
      n_tests++; if (hit_rise !== '0) begin n_fail++; $display("FAIL clr hit_rise: got %b want 0", hit_rise); end
      drive(1'b1, 1'b0, av);
      n_tests++; if (run_len[0 +: LW] !== LW'(1)) begin n_fail++; $display("FAIL clr next run_len: got %0d want 1", run_len[0 +: LW]); end
      advance();
      n_tests++; if (hit_rise[0] !== 1'b0) begin n_fail++; $display("FAIL clr next hit_rise: got %b want 0", hit_rise[0]); end
   endtask

   task automatic test_async_reset();
      logic [CH-1:0] av;
      mode = 2'b10; thresh = LW'(1);
      do_clear();
      av = CH'($urandom);
      av[1] = 1'b1;
      drive(1'b1, 1'b0, av);
      advance();
      n_tests++; if (hit_rise[1] !== 1'b1) begin n_fail++; $display("FAIL areset pre hit_rise: got %b want 1", hit_rise[1]); end
      #1 reset = 1'b0;
      #1;
      n_tests++; if (hit_rise !== '0) begin n_fail++; $display("FAIL areset hit_rise: got %b want 0", hit_rise); end
      #3 reset = 1'b1;
      m_reset();
      drive(1'b1, 1'b0, CH'($urandom));
      for (int c = 0; c < CH; c++) begin
         n_tests++; if (run_len[c*LW +: LW] !== LW'(1)) begin n_fail++; $display("FAIL areset next run_len ch%0d: got %0d want 1", c, run_len[c*LW +: LW]); end
      end
      advance();
   endtask

   task automatic test_random();
      logic [LW-1:0] e_rl;
      bit            e_hit;
      bit            take;
      for (int n = 0; n < 400; n++) begin
         if ((n % 20) == 0) mode = 2'($urandom);
         if ((n % 7) == 0)  thresh = LW'($urandom_range(0, 15));
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), CH'($urandom));
         take = valid && !clr;
         for (int c = 0; c < CH; c++) begin
            e_rl  = take ? LW'(m_run(c, a[c])) : '0;
            e_hit = take && m_hit(c, a[c]);
            n_tests++; if (run_len[c*LW +: LW] !== e_rl) begin n_fail++; $display("FAIL rand run_len n%0d ch%0d: got %0d want %0d", n, c, run_len[c*LW +: LW], e_rl); end
            n_tests++; if ((x[c] !== (e_rl >= 2)) || (y[c] !== (e_rl >= 3))) begin n_fail++; $display("FAIL rand x/y n%0d ch%0d: got %b%b want %b%b", n, c, x[c], y[c], (e_rl >= 2), (e_rl >= 3)); end
            n_tests++; if (hit[c] !== e_hit) begin n_fail++; $display("FAIL rand hit n%0d ch%0d: got %b want %b", n, c, hit[c], e_hit); end
         end
         advance();
         for (int c = 0; c < CH; c++) begin
            n_tests++; if (hit_rise[c] !== exp_rise[c]) begin n_fail++; $display("FAIL rand hit_rise n%0d ch%0d: got %b want %b", n, c, hit_rise[c], exp_rise[c]); end
         end
      end
   endtask

   initial begin
      test_reset();
      @(posedge clk);
      #1;
      test_legacy_run();
      test_saturation();
      test_mode_zeros();
      test_gap();
      test_clear();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/history_detector.md
# history_detector

Parametrised, multi-channel successor to the single-bit two/three-deep history FSM. Each channel tracks the length of the current run of identical input samples, up to `DEPTH`. Per sample it reports:
- the run length,
- legacy "last two equal" (`x`) and "last three equal" (`y`) flags,
- a programmable-threshold match with polarity mode,
- a registered rising-edge event.

It sits between the input synchroniser and the control sequencer, with one channel per monitored line.

## Interface
Parameters:
- `CH`, 4: number of independent channels.
- `DEPTH`, 8: saturation limit of the run counter; legal range is 3 and up.
- `LW`, `$clog2(DEPTH+1)`: derived run-length width; not overridable.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `valid`  in  1  a sample is present on `a` this cycle.
- `clr`  in  1  synchronous history clear for all channels.
- `a`  in  CH  sample bit per channel.
- `mode`  in  2  polarity filter for `hit`: 00 = runs of 1s, 01 = runs of 0s, 10/11 = both.
- `thresh`  in  LW  run length (current sample included) at which `hit` asserts.
- `run_len`  out  CH×LW  current run length per channel, combinational.
- `x`  out  CH  run ≥ 2, combinational.
- `y`  out  CH  run ≥ 3, combinational.
- `hit`  out  CH  threshold match, combinational.
- `hit_rise`  out  CH  registered one-cycle pulse on the first `hit` of a run.

## Operation
Per-channel state:
- `last`: 1 bit.
- `cnt`: LW bits, number of consecutive equal past samples, saturating at DEPTH.
- `hit_q`: 1 bit, `hit` of the last accepted sample.
- `cnt == 0` means no history.

Combinational path (Mealy, as in the legacy block):
- Outputs are computed when `valid=1` and `clr=0`.
- `cur = (cnt != 0 && a == last) ? min(cnt+1, DEPTH) : 1`.
- `run_len = cur`; `x = (cur >= 2)`; `y = (cur >= 3)`.
- `hit = (cur >= thresh) && polarity_ok`, where polarity_ok = `a==1` for mode 00, `a==0` for mode 01, always 1 for 10/11.
- When `valid=0` or `clr=1`: `run_len`, `x`, `y` and `hit` are all 0.

State update on a rising edge:
- `clr=1` (priority over `valid`): `cnt←0`, `last←0`, `hit_q←0`, `hit_rise←0`. The sample on `a` is discarded.
- `valid=1`, `clr=0`: `last←a`, `cnt←cur`, `hit_q←hit`, `hit_rise←hit & ~hit_q`.
- `valid=0`, `clr=0`: state held, `hit_rise←0`. Gaps do not break a run.

Boundary conditions:
- `thresh` of 0 or 1: every polarity-matching valid sample hits; `hit_rise` fires on the first such sample after a non-hit or a clear.
- `thresh > DEPTH`: `hit` is never asserted.
- Saturation: `cnt` stays at DEPTH. `hit` stays high for the whole run and `hit_rise` stays low after its pulse.
- Polarity change mid-run (a flips): run restarts at 1. `hit_rise` can fire again on the new run if it reaches threshold.
- `mode` and `thresh` changes take effect on the next valid sample. No state is flushed.

Channels are fully independent; `valid`, `clr`, `mode` and `thresh` are shared.

## Timing
- Reset (`reset=0`, asynchronous): all `cnt=0`, `last=0`, `hit_q=0`, `hit_rise=0`. Combinational outputs are then 0 until `valid`.
- Reset deasserts synchronously to `clk` (external synchroniser). Reset asserted mid-run discards all history immediately.
- Latency: `run_len`/`x`/`y`/`hit` are zero-cycle, same cycle as `valid`. `hit_rise` is one cycle after the hitting sample.
- No back-pressure: a sample is accepted in every cycle where `valid=1`.

## Structure
- Package `history_pkg` holds:
  - the `mode_t` enum `{MODE_ONES=2'b00, MODE_ZEROS=2'b01, MODE_BOTH=2'b10}` (2'b11 decoded as BOTH);
  - the `LW` computation function.
- One sub-module, `history_chan`: a single channel with the state, saturating counter and output logic. The top is a `generate` loop over CH instances plus port packing.
- With CH=1, DEPTH=3, thresh=3 and mode=BOTH, `x`/`y` reproduce the legacy block exactly.

## Test plan
- Reset then `valid=1`, ch0 `a`=0,0,0,0 → `run_len` 1,2,3,4; `x` 0,1,1,1; `y` 0,0,1,1.
- DEPTH=8, thresh=3, mode=00, ch1 `a`=1 for 10 samples → `run_len` saturates at 8. `hit` is high from sample 3 on. `hit_rise` is high only in the cycle after sample 3.
- mode=01, thresh=2, `a`=1,1,1,0,0 → `hit` 0,0,0,0,1; `x` 0,1,1,0,1.
- `a`=1,1 then `valid=0` for 5 cycles, then `a`=1 → third sample gives `run_len=3`. All outputs are 0 during the gap.
- `clr=1` together with `valid=1` after a run of 5 → outputs 0 that cycle; next sample gives `run_len=1` and `hit_rise` 0.
- `reset` pulled low mid-run for less than one clock period → `hit_rise` 0 immediately. Next sample gives `run_len=1`. Other channels are unaffected by each other's stimulus throughout.
